// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the decoder MDUop encoding, the controller state encoding and a
// small helper that classifies an op as one that starts a multi-cycle operation.
package mdu_pkg;

    // Decoder MDUop encoding
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_DIV_RUN  = 3'd3,
        ST_DIV_FIX  = 3'd4
    } state_t;

    // True for mult, multu, div and divu
    function automatic logic is_mdu_start(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               load operands and begin (one cycle)
//   dividend, divisor   unsigned operands, sampled when start=1
//   done                one-cycle pulse, WIDTH+1 cycles after the start cycle
//   quotient, remainder results, valid while done=1
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             active;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: shift the next dividend bit into the partial remainder
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, dvs}) begin
            rem_next = WIDTH'(shifted - {1'b0, dvs});
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= '0;
                quo    <= dividend;
                dvs    <= divisor;
                cnt    <= CNT_W'(WIDTH);
                active <= 1'b1;
            end else if (active) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op                decoder MDUop
//   kill              squash the current E-stage instruction
//   rs_data, rt_data  forwarded operands
//   busy              registered, operation in flight
//   stall_req         comb, busy or a start op being presented
//   hi, lo            HI/LO registers
//   mf_data           comb, HI for mfhi, LO for mflo, else zero
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned DIV_ITER    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             kill,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int unsigned DIV_N   = (DIV_ITER != 0) ? WIDTH + 1 : DIV_CYCLES;
    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_N) ? MULT_CYCLES : DIV_N;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PROD_W  = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_we;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic             accept;
    logic             result_we;
    logic             mthi_we;
    logic             mtlo_we;
    logic             busy_next;

    logic             is_start;
    logic             is_mul;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;

    logic [WIDTH-1:0] dq_mag;
    logic [WIDTH-1:0] dr_mag;
    logic             div_done;
    logic             use_q_neg;
    logic             use_r_neg;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // Operand decode and magnitude preparation
    assign is_start  = is_mdu_start(op);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = is_signed & rs_data[WIDTH-1];
    assign b_neg     = is_signed & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;
    assign a_ext     = is_signed ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
    assign b_ext     = is_signed ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
    assign prod      = a_ext * b_ext;

    assign accept = (state == ST_IDLE) && is_start && !kill;

    // Divider: single-cycle combinational at accept, or iterative sub-module
    if (DIV_ITER == 0) begin : g_div_comb
        logic [WIDTH-1:0] den;
        // Substitute 1 for a zero divisor; the result is discarded anyway
        assign den      = (b_mag == '0) ? WIDTH'(1) : b_mag;
        assign dq_mag   = a_mag / den;
        assign dr_mag   = a_mag % den;
        assign div_done = 1'b0;
    end else begin : g_div_iter
        logic div_start;
        assign div_start = accept && !is_mul;
        mdu_divider #(
            .WIDTH(WIDTH)
        ) u_div (
            .clk      (clk),
            .reset    (reset),
            .start    (div_start),
            .dividend (a_mag),
            .divisor  (b_mag),
            .done     (div_done),
            .quotient (dq_mag),
            .remainder(dr_mag)
        );
    end

    // Sign fix-up: latched signs in DIV_FIX, live signs at accept otherwise.
    // MIN / -1 falls out naturally: |MIN| = MIN, negated back to MIN.
    assign use_q_neg = (state == ST_DIV_FIX) ? q_neg : (a_neg ^ b_neg);
    assign use_r_neg = (state == ST_DIV_FIX) ? r_neg : a_neg;
    assign div_q     = use_q_neg ? -dq_mag : dq_mag;
    assign div_r     = use_r_neg ? -dr_mag : dr_mag;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_next = ST_MUL_WAIT;
                    end else if (DIV_ITER != 0) begin
                        state_next = ST_DIV_RUN;
                    end else begin
                        state_next = ST_DIV_WAIT;
                    end
                end
            end
            ST_MUL_WAIT, ST_DIV_WAIT: begin
                if (cnt == '0) state_next = ST_IDLE;
            end
            ST_DIV_RUN: begin
                if (cnt == '0) state_next = ST_DIV_FIX;
            end
            ST_DIV_FIX: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Control outputs: counter, HI/LO write strobes, busy
    always_comb begin
        cnt_next  = cnt;
        result_we = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        busy_next = (state_next != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        cnt_next = CNT_W'(MULT_CYCLES - 1);
                    end else if (DIV_ITER != 0) begin
                        cnt_next = CNT_W'(WIDTH - 1);
                    end else begin
                        cnt_next = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                mthi_we = (op == OP_MTHI) && !kill;
                mtlo_we = (op == OP_MTLO) && !kill;
            end
            ST_MUL_WAIT, ST_DIV_WAIT: begin
                if (cnt == '0) begin
                    result_we = res_we;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_DIV_RUN: begin
                if (cnt != '0) cnt_next = cnt - CNT_W'(1);
            end
            ST_DIV_FIX: result_we = div_done && !div_zero;
            default: ;
        endcase
    end

    // Datapath: staged results and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_we   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            cnt  <= cnt_next;
            busy <= busy_next;
            if (accept) begin
                if (is_mul) begin
                    res_hi <= prod[PROD_W-1:WIDTH];
                    res_lo <= prod[WIDTH-1:0];
                    res_we <= 1'b1;
                end else begin
                    res_hi <= div_r;
                    res_lo <= div_q;
                    res_we <= (b_mag != '0);
                end
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
                div_zero <= (b_mag == '0);
            end
            if (result_we) begin
                if (state == ST_DIV_FIX) begin
                    hi <= div_r;
                    lo <= div_q;
                end else begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                if (mthi_we) hi <= rs_data;
                if (mtlo_we) lo <= rs_data;
            end
        end
    end

    assign stall_req = busy | (is_start & !kill);
    assign mf_data   = (op == OP_MFHI) ? hi :
                       (op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: one instance with the staged divider (a),
// one with the iterative divider (b); expected values are hand-computed.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        kill;
    logic [31:0] rs;
    logic [31:0] rt;

    logic        busy_a, stall_a, busy_b, stall_b;
    logic [31:0] hi_a, lo_a, mf_a, hi_b, lo_b, mf_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic stall_seen;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .DIV_ITER(0)) u_a (
        .clk(clk), .reset(reset), .op(op_a), .kill(kill),
        .rs_data(rs), .rt_data(rt), .busy(busy_a), .stall_req(stall_a),
        .hi(hi_a), .lo(lo_a), .mf_data(mf_a)
    );

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .DIV_ITER(1)) u_b (
        .clk(clk), .reset(reset), .op(op_b), .kill(kill),
        .rs_data(rs), .rt_data(rt), .busy(busy_b), .stall_req(stall_b),
        .hi(hi_b), .lo(lo_b), .mf_data(mf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present an op for one clock edge; called and returns at a negedge
    task automatic issue(input int sel, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic k);
        rs   = a;
        rt   = b;
        kill = k;
        if (sel == 0) op_a = o; else op_b = o;
        #1;
        stall_seen = (sel == 0) ? stall_a : stall_b;
        @(negedge clk);
        op_a = 4'd0;
        op_b = 4'd0;
        kill = 1'b0;
    endtask

    // Count cycles until busy drops, bounded
    task automatic wait_idle(input int sel, output int n);
        n = 0;
        while (((sel == 0) ? busy_a : busy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        op_a  = 4'd0;
        op_b  = 4'd0;
        kill  = 1'b0;
        rs    = '0;
        rt    = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_hi_a", hi_a, 32'd0);
        chk("reset_lo_a", lo_a, 32'd0);
        chk("reset_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // mult -2 * 3
        issue(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_stall", 32'(stall_seen), 32'd1);
        chk("mult_busy_t1", 32'(busy_a), 32'd1);
        chk("mult_hi_stale", hi_a, 32'd0);
        wait_idle(0, cyc);
        chk("mult_cycles", 32'(cyc), 32'd5);
        chk("mult_hi", hi_a, 32'hFFFF_FFFF);
        chk("mult_lo", lo_a, 32'hFFFF_FFFA);

        // multu, back-to-back with the previous op
        issue(0, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle(0, cyc);
        chk("multu_cycles", 32'(cyc), 32'd5);
        chk("multu_hi", hi_a, 32'h0000_0002);
        chk("multu_lo", lo_a, 32'hFFFF_FFFA);

        // mfhi / mflo / none
        op_a = 4'd5; #1;
        chk("mfhi", mf_a, 32'h0000_0002);
        op_a = 4'd6; #1;
        chk("mflo", mf_a, 32'hFFFF_FFFA);
        op_a = 4'd0; #1;
        chk("mf_none", mf_a, 32'd0);
        @(negedge clk);

        // divu 100 / 7
        issue(0, 4'd4, 32'd100, 32'd7, 1'b0);
        wait_idle(0, cyc);
        chk("divu_cycles", 32'(cyc), 32'd10);
        chk("divu_lo", lo_a, 32'd14);
        chk("divu_hi", hi_a, 32'd2);

        // div -7 / 2, staged divider
        issue(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(0, cyc);
        chk("div_a_cycles", 32'(cyc), 32'd10);
        chk("div_a_lo", lo_a, 32'hFFFF_FFFD);
        chk("div_a_hi", hi_a, 32'hFFFF_FFFF);

        // div -7 / 2, iterative divider
        issue(1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_b_busy_t1", 32'(busy_b), 32'd1);
        wait_idle(1, cyc);
        chk("div_b_cycles", 32'(cyc), 32'd33);
        chk("div_b_lo", lo_b, 32'hFFFF_FFFD);
        chk("div_b_hi", hi_b, 32'hFFFF_FFFF);

        // MIN / -1 on both
        issue(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(0, cyc);
        chk("min_a_lo", lo_a, 32'h8000_0000);
        chk("min_a_hi", hi_a, 32'd0);
        issue(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(1, cyc);
        chk("min_b_lo", lo_b, 32'h8000_0000);
        chk("min_b_hi", hi_b, 32'd0);

        // Preset HI/LO then divide by zero
        issue(0, 4'd7, 32'h11, 32'd0, 1'b0);
        chk("mthi_a", hi_a, 32'h11);
        issue(0, 4'd8, 32'h22, 32'd0, 1'b0);
        chk("mtlo_a", lo_a, 32'h22);
        issue(0, 4'd3, 32'd5, 32'd0, 1'b0);
        wait_idle(0, cyc);
        chk("dz_a_cycles", 32'(cyc), 32'd10);
        chk("dz_a_hi", hi_a, 32'h11);
        chk("dz_a_lo", lo_a, 32'h22);

        issue(1, 4'd7, 32'h11, 32'd0, 1'b0);
        issue(1, 4'd8, 32'h22, 32'd0, 1'b0);
        issue(1, 4'd4, 32'd5, 32'd0, 1'b0);
        wait_idle(1, cyc);
        chk("dz_b_cycles", 32'(cyc), 32'd33);
        chk("dz_b_hi", hi_b, 32'h11);
        chk("dz_b_lo", lo_b, 32'h22);

        // Killed mthi leaves HI alone
        issue(0, 4'd7, 32'h1234, 32'd0, 1'b1);
        chk("kill_mthi_hi", hi_a, 32'h11);

        // Killed mult never starts
        issue(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("kill_mult_stall", 32'(stall_seen), 32'd0);
        chk("kill_mult_busy", 32'(busy_a), 32'd0);
        repeat (6) @(negedge clk);
        chk("kill_mult_lo", lo_a, 32'h22);

        // Reset in the third busy cycle of a mult
        issue(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_hi", hi_a, 32'd0);
        chk("rst_mid_lo", lo_a, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_hi_later", hi_a, 32'd0);
        chk("rst_mid_busy_later", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
